prbs_checker: RTL and testbench

Serial receive-side checker for the team's Fibonacci LFSR pseudo-random bit source. It takes the generator's bit stream one bit per valid cycle and synchronises to the sequence. Once locked, it free-runs its own reference LFSR and reports each bit mismatch and a saturating error count. It sits at the far end of a link or loopback path, opposite the LFSR generator, for built-in self-test.

---
 rtl/prbs_checker.sv | 99 +++++++++
 tb/tb_prbs_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Receive-side checker for the Fibonacci LFSR bit source: searches for the
// sequence, then free-runs a reference LFSR and counts bit mismatches.
module prbs_checker #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter int               LOCK_CNT   = 8,
  parameter int               MISS_LIMIT = 4,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [7:0]        LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]        MISS_LAST = 8'(MISS_LIMIT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [FILL_W-1:0] fill;
  logic [7:0]        match;
  logic [7:0]        miss;
  logic              pred;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pred = ^(shreg & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEARCH;
      shreg   <= '0;
      fill    <= '0;
      match   <= '0;
      miss    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            shreg <= {shreg[WIDTH-2:0], in_bit};
            if (fill < FILL_FULL) begin
              fill <= fill + 1'b1;
            end else if ((in_bit == pred) && (shreg != '0)) begin
              if (match == LOCK_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
                match  <= '0;
                miss   <= '0;
              end else begin
                match <= match + 1'b1;
              end
            end else begin
              // an all-zero register predicts zeros forever, so it never counts
              match <= '0;
            end
          end
          LOCKED: begin
            shreg <= {shreg[WIDTH-2:0], pred};
            if (in_bit != pred) begin
              err     <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
              if (miss == MISS_LAST) begin
                state  <= SEARCH;
                locked <= 1'b0;
                shreg  <= '0;
                fill   <= '0;
                match  <= '0;
                miss   <= '0;
              end else begin
                miss <= miss + 1'b1;
              end
            end else begin
              miss <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // clear takes priority over a coincident counted mismatch
      if (clr_cnt) err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: expectations are queued as bits are driven
// and compared after each rising edge; a CNT_W=4 twin shares the stimulus.
module tb_prbs_checker;

  logic        clk;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic        locked4;
  logic        err4;
  logic [3:0]  err_cnt4;

  prbs_checker dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .locked(locked4), .err(err4), .err_cnt(err_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          errors;
  int          checks;
  logic [3:0]  g;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt4;

  task automatic gen_bit(output logic b);
    b = g[3] ^ g[2];
    g = {g[2:0], b};
  endtask

  task automatic count_err(input logic clr);
    if (clr) begin
      exp_cnt  = '0;
      exp_cnt4 = '0;
    end else begin
      exp_cnt  = exp_cnt + 1'b1;
      exp_cnt4 = (exp_cnt4 == 4'hf) ? 4'hf : exp_cnt4 + 1'b1;
    end
  endtask

  task automatic send(input logic b, input logic v, input logic clr,
                      input logic el, input logic ee);
    exp_t x;
    @(negedge clk);
    in_bit   = b;
    in_valid = v;
    clr_cnt  = clr;
    x.locked = el;
    x.err    = ee;
    x.cnt    = exp_cnt;
    x.cnt4   = exp_cnt4;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    exp_cnt  = '0;
    exp_cnt4 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (locked !== 1'b0 || locked4 !== 1'b0) begin
      errors++; $display("FAIL reset_locked: got %b/%b expected 0", locked, locked4);
    end
    checks++;
    if (err !== 1'b0 || err4 !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b/%b expected 0", err, err4);
    end
    checks++;
    if (err_cnt !== 16'd0 || err_cnt4 !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0", err_cnt, err_cnt4);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    logic b;
    g = 4'b0001;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b);
      send(b, 1'b1, 1'b0, i >= 12, 1'b0);
    end
  endtask

  task automatic test_single_flip();
    logic b;
    for (int i = 0; i < 5; i++) begin
      gen_bit(b); send(b, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    gen_bit(b); count_err(1'b0); send(~b, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      gen_bit(b); send(b, 1'b1, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_valid_gaps();
    logic b;
    int   k;
    do_reset();
    g = 4'b0001;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      gen_bit(b);
      k++;
      send(b, 1'b1, 1'b0, k >= 12, 1'b0);
      send(1'($urandom_range(1, 0)), 1'b0, 1'b0, k >= 12, 1'b0);
    end
  endtask

  task automatic test_clr_collision();
    logic b;
    for (int i = 0; i < 3; i++) begin
      gen_bit(b); count_err(1'b0); send(~b, 1'b1, 1'b0, 1'b1, 1'b1);
      gen_bit(b); send(b, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    gen_bit(b); count_err(1'b1); send(~b, 1'b1, 1'b1, 1'b1, 1'b1);
    gen_bit(b); send(b, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    logic b;
    for (int i = 0; i < 20; i++) begin
      gen_bit(b); count_err(1'b0); send(~b, 1'b1, 1'b0, 1'b1, 1'b1);
      gen_bit(b); send(b, 1'b1, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_zero_stream();
    logic b;
    logic ee;
    logic dropped;
    int   consec;
    dropped = 1'b0;
    consec  = 0;
    for (int i = 0; i < 45; i++) begin
      gen_bit(b);
      ee = 1'b0;
      if (!dropped) begin
        if (b) begin
          consec++;
          count_err(1'b0);
          ee = 1'b1;
          if (consec == 4) dropped = 1'b1;
        end else begin
          consec = 0;
        end
      end
      send(1'b0, 1'b1, 1'b0, !dropped, ee);
    end
  endtask

  task automatic test_async_reset();
    logic b;
    do_reset();
    g = 4'b0001;
    for (int i = 1; i <= 15; i++) begin
      gen_bit(b); send(b, 1'b1, 1'b0, i >= 12, 1'b0);
    end
    gen_bit(b); count_err(1'b0); send(~b, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || locked4 !== 1'b0) begin
      errors++; $display("FAIL async_locked: got %b/%b expected 0", locked, locked4);
    end
    checks++;
    if (err !== 1'b0 || err4 !== 1'b0) begin
      errors++; $display("FAIL async_err: got %b/%b expected 0", err, err4);
    end
    checks++;
    if (err_cnt !== 16'd0 || err_cnt4 !== 4'd0) begin
      errors++; $display("FAIL async_cnt: got %0d/%0d expected 0", err_cnt, err_cnt4);
    end
    @(posedge clk);
    #3;
    rst      = 1'b0;
    exp_cnt  = '0;
    exp_cnt4 = '0;
    g = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      gen_bit(b); send(b, 1'b1, 1'b0, i >= 12, 1'b0);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    exp_cnt  = '0;
    exp_cnt4 = '0;
    g        = 4'b0001;
    fork
      begin
        forever begin
          @(posedge clk);
          #1;
          if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (locked !== e.locked || locked4 !== e.locked) begin
              errors++;
              $display("FAIL locked @%0t: got %b/%b expected %b", $time, locked, locked4, e.locked);
            end
            checks++;
            if (err !== e.err || err4 !== e.err) begin
              errors++;
              $display("FAIL err @%0t: got %b/%b expected %b", $time, err, err4, e.err);
            end
            checks++;
            if (err_cnt !== e.cnt) begin
              errors++;
              $display("FAIL err_cnt @%0t: got %0d expected %0d", $time, err_cnt, e.cnt);
            end
            checks++;
            if (err_cnt4 !== e.cnt4) begin
              errors++;
              $display("FAIL err_cnt4 @%0t: got %0d expected %0d", $time, err_cnt4, e.cnt4);
            end
          end
        end
      end
      begin
        test_reset();
        test_lock();
        test_single_flip();
        test_valid_gaps();
        test_clr_collision();
        test_saturation();
        test_zero_stream();
        test_async_reset();
        repeat (2) @(posedge clk);
        #2;
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
